// File: rtl/blinky_pkg.sv
// Shared helpers and derived constants for the blue-LED blinker.
// Sizing functions are used by the top to derive its divider geometry from its own parameters.
package blinky_pkg;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned width;
      width = 0;
      while ((32'd1 << width) < value) width++;
      return (width == 0) ? 1 : width;
   endfunction

   function automatic int unsigned half_cycles(input int unsigned clk_hz,
                                               input int unsigned blink_hz);
      return clk_hz / (2 * blink_hz);
   endfunction

   // Board defaults: 125 MHz clock, 1 Hz blink.
   localparam int unsigned DEF_CLK_HZ   = 125_000_000;
   localparam int unsigned DEF_BLINK_HZ = 1;
   localparam int unsigned HALF         = half_cycles(DEF_CLK_HZ, DEF_BLINK_HZ);
   localparam int unsigned DIV_W        = clog2(HALF);

endpackage

// File: rtl/blinky_led_btn_sync.sv
// Two-flop synchronizer that brings the asynchronous push-button into the clk domain.
// The flops carry no reset: they are the source of the reset.
module btn_sync (
   input  logic clk,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      meta_q <= d_i;
      sync_q <= meta_q;
   end

   assign q_o = sync_q;

endmodule

// File: rtl/blinky_led.sv
// Blue LED blinker: HALF-cycle on/off envelope, PWM-dimmed to DUTY/2^PWM_BITS while on.
// btn is synchronized and then used as the synchronous active-high reset of all logic.
module blinky_led
   import blinky_pkg::*;
#(
   parameter int unsigned CLK_HZ   = DEF_CLK_HZ,
   parameter int unsigned BLINK_HZ = DEF_BLINK_HZ,
   parameter int unsigned PWM_BITS = 8,
   parameter int unsigned DUTY     = 32
) (
   input  logic clk,
   input  logic btn,
   output logic led0_b
);

   localparam int unsigned T_HALF  = half_cycles(CLK_HZ, BLINK_HZ);
   localparam int unsigned T_DIV_W = clog2(T_HALF);
   localparam logic [T_DIV_W-1:0]  DIV_LAST = T_DIV_W'(T_HALF - 1);
   // One extra bit so DUTY = 2^PWM_BITS compares true for every counter value.
   localparam logic [PWM_BITS:0]   DUTY_C   = (PWM_BITS + 1)'(DUTY);

   if (T_HALF < 2) begin : g_half_chk
      $error("blinky_led: HALF must be at least 2");
   end
   if (DUTY > (1 << PWM_BITS)) begin : g_duty_chk
      $error("blinky_led: DUTY exceeds 2^PWM_BITS");
   end

   logic                 rst_s;
   logic [T_DIV_W-1:0]   div_cnt_q, div_cnt_d;
   logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
   logic                 phase_q,   phase_d;
   logic                 led_q,     led_d;

   btn_sync u_btn_sync (
      .clk (clk),
      .d_i (btn),
      .q_o (rst_s)
   );

   always_comb begin
      div_cnt_d = div_cnt_q + T_DIV_W'(1);
      phase_d   = phase_q;
      if (div_cnt_q == DIV_LAST) begin
         div_cnt_d = '0;
         phase_d   = ~phase_q;
      end
      pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
      led_d     = phase_q & ({1'b0, pwm_cnt_q} < DUTY_C);
   end

   // Reset leaves phase high so every restart begins with an on-phase.
   always_ff @(posedge clk) begin
      if (rst_s) begin
         div_cnt_q <= '0;
         pwm_cnt_q <= '0;
         phase_q   <= 1'b1;
         led_q     <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         pwm_cnt_q <= pwm_cnt_d;
         phase_q   <= phase_d;
         led_q     <= led_d;
      end
   end

   assign led0_b = led_q;

endmodule

// File: tb/tb_blinky_led.sv
// Bench for blinky_led: three duty settings share one button and are checked every cycle
// against a cycle-count model of the blink envelope and PWM pattern.
module tb_blinky_led;

   localparam int unsigned HALF       = 25;
   localparam int unsigned PWM_PERIOD = 4;

   logic clk;
   logic btn;
   logic led_d2;
   logic led_d4;
   logic led_d0;

   int total;
   int bad;
   int edge_n;
   int run_cnt;
   logic prev1;
   logic prev2;
   logic in_reset;

   blinky_led #(.CLK_HZ(1000), .BLINK_HZ(20), .PWM_BITS(2), .DUTY(2)) u_d2 (
      .clk (clk), .btn (btn), .led0_b (led_d2));
   blinky_led #(.CLK_HZ(1000), .BLINK_HZ(20), .PWM_BITS(2), .DUTY(4)) u_d4 (
      .clk (clk), .btn (btn), .led0_b (led_d4));
   blinky_led #(.CLK_HZ(1000), .BLINK_HZ(20), .PWM_BITS(2), .DUTY(0)) u_d0 (
      .clk (clk), .btn (btn), .led0_b (led_d0));

   initial clk = 1'b0;
   always #8 clk = ~clk;

   // r counts clock edges since the logic left reset; on-phase for the first HALF of each 2*HALF.
   function automatic logic exp_led(input int duty, input int r);
      return (((r / HALF) % 2) == 0) && ((r % PWM_PERIOD) < duty);
   endfunction

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_n, obs, exp);
      end
   endtask

   // One clock: drive btn at the falling edge, model the sampled value, check after the rise.
   task automatic tick(input logic b);
      logic e2, e4, e0;
      @(negedge clk);
      btn = b;
      @(posedge clk);
      edge_n++;
      in_reset = prev2;
      prev2 = prev1;
      prev1 = b;
      if (in_reset) begin
         e2 = 1'b0; e4 = 1'b0; e0 = 1'b0;
         run_cnt = 0;
      end else begin
         e2 = exp_led(2, run_cnt);
         e4 = exp_led(4, run_cnt);
         e0 = exp_led(0, run_cnt);
         run_cnt++;
      end
      #1;
      if (edge_n >= 3) begin
         check_bit("led_duty2", led_d2, e2);
         check_bit("led_duty4", led_d4, e4);
         check_bit("led_duty0", led_d0, e0);
      end
   endtask

   initial begin
      int n;
      total    = 0;
      bad      = 0;
      edge_n   = 0;
      run_cnt  = 0;
      prev1    = 1'b1;
      prev2    = 1'b1;
      in_reset = 1'b1;
      btn      = 1'b1;

      // Held reset: output dark, counters cleared, phase ready for on-first.
      for (int i = 0; i < 20; i++) tick(1'b1);
      total++;
      assert (u_d2.div_cnt_q === 5'd0) else begin
         bad++; $error("FAIL div_cnt_rst observed=%0d expected=0", u_d2.div_cnt_q);
      end
      total++;
      assert (u_d2.pwm_cnt_q === 2'd0) else begin
         bad++; $error("FAIL pwm_cnt_rst observed=%0d expected=0", u_d2.pwm_cnt_q);
      end
      total++;
      assert (u_d2.phase_q === 1'b1) else begin
         bad++; $error("FAIL phase_rst observed=%b expected=1", u_d2.phase_q);
      end

      // Release and run two blink periods.
      for (int i = 0; i < 110; i++) tick(1'b0);

      // Reach the middle of an on-phase, then hold btn for 2000 ns.
      n = 0;
      while (!(((run_cnt / HALF) % 2 == 0) && (run_cnt % HALF == 12)) && n < 200) begin
         tick(1'b0);
         n++;
      end
      total++;
      assert (n < 200) else begin
         bad++; $error("FAIL reach_mid_on observed=%0d expected<200", n);
      end
      for (int i = 0; i < 125; i++) tick(1'b1);
      for (int i = 0; i < 110; i++) tick(1'b0);

      // Single-cycle pulse during the off-phase restarts on-phase first.
      n = 0;
      while (!(((run_cnt / HALF) % 2 == 1) && (run_cnt % HALF == 7)) && n < 200) begin
         tick(1'b0);
         n++;
      end
      total++;
      assert (n < 200) else begin
         bad++; $error("FAIL reach_mid_off observed=%0d expected<200", n);
      end
      tick(1'b1);
      for (int i = 0; i < 80; i++) tick(1'b0);

      // Long run for drift: ten blink periods from a fresh release.
      tick(1'b1);
      for (int i = 0; i < 520; i++) tick(1'b0);

      // Random reset pulses and run lengths.
      for (int k = 0; k < 20; k++) begin
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) tick(1'b1);
         n = $urandom_range(5, 120);
         for (int i = 0; i < n; i++) tick(1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
